// File: rtl/mem_stage.sv
// Memory-access pipeline stage: load/store issue over a req/gnt/rvalid handshake with registered MEM-WB outputs.
// Define MEM_MISALIGN_TRAP_EN to flag misaligned accesses instead of force-aligning them.
module mem_stage #(
   parameter int WIDTH    = 32,
   parameter int ADDR_LEN = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                valid_i,
   input  logic [ADDR_LEN-1:0] pc_i,
   input  logic [WIDTH-1:0]    alu_out_i,
   input  logic [WIDTH-1:0]    rs2_value_i,
   input  logic [1:0]          mem_op_i,
   input  logic [1:0]          mem_size_i,
   input  logic                mem_unsigned_i,
   input  logic [4:0]          rd_i,
   input  logic                reg_we_i,
   output logic                stall_o,
   output logic                dmem_req,
   output logic                dmem_we,
   output logic [ADDR_LEN-1:0] dmem_addr,
   output logic [3:0]          dmem_be,
   output logic [WIDTH-1:0]    dmem_wdata,
   input  logic                dmem_gnt,
   input  logic                dmem_rvalid,
   input  logic [WIDTH-1:0]    dmem_rdata,
   output logic                valid_o,
   output logic [ADDR_LEN-1:0] pc_o,
   output logic [4:0]          rd_o,
   output logic                reg_we_o,
   output logic [WIDTH-1:0]    wb_data_o,
   output logic                misaligned_o
);

   typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

   state_t           state;
   logic             is_load;
   logic             is_store;
   logic             trap;
   logic             mem_go;
   logic [1:0]       off;
   logic [3:0]       be;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] load_data;

   // Decode the access and choose the effective byte offset
   always_comb begin
      is_load  = valid_i && (mem_op_i == 2'b01);
      is_store = valid_i && (mem_op_i == 2'b10);
`ifdef MEM_MISALIGN_TRAP_EN
      trap = (is_load || is_store) &&
             (((mem_size_i == 2'b01) && alu_out_i[0]) ||
              (mem_size_i[1] && (alu_out_i[1:0] != 2'b00)));
      off  = alu_out_i[1:0];
`else
      trap = 1'b0;
      case (mem_size_i)
         2'b00:   off = alu_out_i[1:0];
         2'b01:   off = {alu_out_i[1], 1'b0};
         default: off = 2'b00;
      endcase
`endif
      mem_go = (is_load || is_store) && !trap;
   end

   // Store lane steering and load extraction
   always_comb begin
      shifted = dmem_rdata >> {off, 3'b000};
      case (mem_size_i)
         2'b00: begin
            be        = 4'b0001 << off;
            wdata     = {4{rs2_value_i[7:0]}};
            load_data = mem_unsigned_i ? {{(WIDTH-8){1'b0}}, shifted[7:0]}
                                       : {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
         end
         2'b01: begin
            be        = 4'b0011 << {off[1], 1'b0};
            wdata     = {2{rs2_value_i[15:0]}};
            load_data = mem_unsigned_i ? {{(WIDTH-16){1'b0}}, shifted[15:0]}
                                       : {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
         end
         default: begin
            be        = 4'b1111;
            wdata     = rs2_value_i;
            load_data = shifted;
         end
      endcase
   end

   // Handshake outputs and upstream stall
   always_comb begin
      case (state)
         IDLE: begin
            dmem_req = mem_go;
            stall_o  = mem_go && !(is_store && dmem_gnt);
         end
         REQ: begin
            dmem_req = 1'b1;
            stall_o  = !(is_store && dmem_gnt);
         end
         WAIT: begin
            dmem_req = 1'b0;
            stall_o  = !dmem_rvalid;
         end
         default: begin
            dmem_req = 1'b0;
            stall_o  = 1'b0;
         end
      endcase
      if (dmem_req) begin
         dmem_we    = is_store;
         dmem_addr  = {alu_out_i[ADDR_LEN-1:2], 2'b00};
         dmem_be    = be;
         dmem_wdata = wdata;
      end else begin
         dmem_we    = 1'b0;
         dmem_addr  = '0;
         dmem_be    = 4'b0000;
         dmem_wdata = '0;
      end
   end

   // FSM and MEM-WB pipeline registers; stalled edges insert bubbles
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         valid_o      <= 1'b0;
         pc_o         <= '0;
         rd_o         <= 5'd0;
         reg_we_o     <= 1'b0;
         wb_data_o    <= '0;
         misaligned_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_go) begin
                  if (dmem_gnt) state <= is_load ? WAIT : IDLE;
                  else          state <= REQ;
               end
            end
            REQ:     if (dmem_gnt) state <= is_load ? WAIT : IDLE;
            WAIT:    if (dmem_rvalid) state <= IDLE;
            default: state <= IDLE;
         endcase
         if (stall_o) begin
            valid_o      <= 1'b0;
            reg_we_o     <= 1'b0;
            misaligned_o <= 1'b0;
         end else begin
            valid_o      <= valid_i;
            pc_o         <= pc_i;
            rd_o         <= rd_i;
            reg_we_o     <= valid_i && reg_we_i && !is_store && !trap;
            wb_data_o    <= (state == WAIT) ? load_data : alu_out_i;
            misaligned_o <= trap;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; honours MEM_MISALIGN_TRAP_EN when defined.
module tb_mem_stage;
   logic        clk = 1'b0;
   logic        reset;
   logic        valid_i;
   logic [31:0] pc_i;
   logic [31:0] alu_out_i;
   logic [31:0] rs2_value_i;
   logic [1:0]  mem_op_i;
   logic [1:0]  mem_size_i;
   logic        mem_unsigned_i;
   logic [4:0]  rd_i;
   logic        reg_we_i;
   logic        stall_o;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        valid_o;
   logic [31:0] pc_o;
   logic [4:0]  rd_o;
   logic        reg_we_o;
   logic [31:0] wb_data_o;
   logic        misaligned_o;

   int errors = 0;
   int checks = 0;

   mem_stage #(.WIDTH(32), .ADDR_LEN(32)) dut (
      .clk(clk), .reset(reset), .valid_i(valid_i), .pc_i(pc_i), .alu_out_i(alu_out_i),
      .rs2_value_i(rs2_value_i), .mem_op_i(mem_op_i), .mem_size_i(mem_size_i),
      .mem_unsigned_i(mem_unsigned_i), .rd_i(rd_i), .reg_we_i(reg_we_i), .stall_o(stall_o),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
      .dmem_rdata(dmem_rdata), .valid_o(valid_o), .pc_o(pc_o), .rd_o(rd_o),
      .reg_we_o(reg_we_o), .wb_data_o(wb_data_o), .misaligned_o(misaligned_o)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      valid_i = 1'b0; pc_i = 32'h0; alu_out_i = 32'h0; rs2_value_i = 32'h0;
      mem_op_i = 2'b00; mem_size_i = 2'b00; mem_unsigned_i = 1'b0; rd_i = 5'd0;
      reg_we_i = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      #1;
      checks++;
      if ({valid_o, reg_we_o, misaligned_o, rd_o, pc_o, wb_data_o} !== 72'h0) begin
         errors++;
         $display("FAIL reset_regs: got valid=%0b we=%0b mis=%0b rd=%0d pc=%h wb=%h, want all 0",
                  valid_o, reg_we_o, misaligned_o, rd_o, pc_o, wb_data_o);
      end
      checks++;
      if ({stall_o, dmem_req, dmem_we, dmem_be, dmem_addr} !== 39'h0) begin
         errors++;
         $display("FAIL reset_comb: got stall=%0b req=%0b we=%0b be=%b addr=%h, want 0",
                  stall_o, dmem_req, dmem_we, dmem_be, dmem_addr);
      end
   endtask

   task automatic test_pass_through();
      int stalls = 0;
      valid_i = 1'b1; pc_i = 32'h100; alu_out_i = 32'h1234; rd_i = 5'd5; reg_we_i = 1'b1;
      #1;
      if (stall_o) stalls++;
      step();
      idle_inputs();
      #1;
      if (stall_o) stalls++;
      checks++;
      if ({valid_o, reg_we_o, rd_o, wb_data_o, pc_o} !== {1'b1, 1'b1, 5'd5, 32'h1234, 32'h100}) begin
         errors++;
         $display("FAIL pass_through: got valid=%0b we=%0b rd=%0d wb=%h pc=%h, want 1 1 5 00001234 00000100",
                  valid_o, reg_we_o, rd_o, wb_data_o, pc_o);
      end
      checks++;
      if (stalls !== 0) begin
         errors++;
         $display("FAIL pass_stall: got %0d stall cycles, want 0", stalls);
      end
   endtask

   task automatic test_byte_store();
      valid_i = 1'b1; mem_op_i = 2'b10; mem_size_i = 2'b00; alu_out_i = 32'h1003;
      rs2_value_i = 32'hAABBCCDD; rd_i = 5'd3; reg_we_i = 1'b1; dmem_gnt = 1'b1;
      #1;
      checks++;
      if ({dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr, stall_o} !==
          {1'b1, 1'b1, 4'b1000, 32'hDDDDDDDD, 32'h1000, 1'b0}) begin
         errors++;
         $display("FAIL byte_store_bus: got req=%0b we=%0b be=%b wd=%h addr=%h stall=%0b, want 1 1 1000 dddddddd 00001000 0",
                  dmem_req, dmem_we, dmem_be, dmem_wdata, dmem_addr, stall_o);
      end
      step();
      idle_inputs();
      checks++;
      if ({valid_o, reg_we_o} !== 2'b10) begin
         errors++;
         $display("FAIL byte_store_wb: got valid=%0b we=%0b, want 1 0", valid_o, reg_we_o);
      end
   endtask

   task automatic test_half_store();
      valid_i = 1'b1; mem_op_i = 2'b10; mem_size_i = 2'b01; alu_out_i = 32'h1002;
      rs2_value_i = 32'h12345678; dmem_gnt = 1'b1;
      #1;
      checks++;
      if ({dmem_be, dmem_wdata} !== {4'b1100, 32'h56785678}) begin
         errors++;
         $display("FAIL half_store_bus: got be=%b wd=%h, want 1100 56785678", dmem_be, dmem_wdata);
      end
      step();
      idle_inputs();
   endtask

   task automatic test_signed_half_load();
      int stalls = 0;
      int bubbles = 0;
      valid_i = 1'b1; mem_op_i = 2'b01; mem_size_i = 2'b01; mem_unsigned_i = 1'b0;
      alu_out_i = 32'h2002; rd_i = 5'd7; reg_we_i = 1'b1; pc_i = 32'h40;
      for (int c = 0; c < 4; c++) begin
         dmem_gnt    = (c == 2);
         dmem_rvalid = (c == 3);
         dmem_rdata  = (c == 3) ? 32'h80010000 : 32'h0;
         #1;
         if (stall_o) stalls++;
         if (c == 1) begin
            checks++;
            if ({dmem_req, dmem_addr, dmem_be} !== {1'b1, 32'h2000, 4'b1100}) begin
               errors++;
               $display("FAIL half_load_req_hold: got req=%0b addr=%h be=%b, want 1 00002000 1100",
                        dmem_req, dmem_addr, dmem_be);
            end
         end
         step();
         if (c < 3 && valid_o) bubbles++;
      end
      idle_inputs();
      checks++;
      if (stalls !== 3) begin
         errors++;
         $display("FAIL half_load_stall: got %0d stall cycles, want 3", stalls);
      end
      checks++;
      if (bubbles !== 0) begin
         errors++;
         $display("FAIL half_load_bubble: got %0d valid cycles during stall, want 0", bubbles);
      end
      checks++;
      if ({valid_o, reg_we_o, rd_o, wb_data_o} !== {1'b1, 1'b1, 5'd7, 32'hFFFF8001}) begin
         errors++;
         $display("FAIL half_load_data: got valid=%0b we=%0b rd=%0d wb=%h, want 1 1 7 ffff8001",
                  valid_o, reg_we_o, rd_o, wb_data_o);
      end
   endtask

   task automatic test_unsigned_byte_load();
      // gnt and a stray rvalid in the issue cycle: the stray data must be ignored
      valid_i = 1'b1; mem_op_i = 2'b01; mem_size_i = 2'b00; mem_unsigned_i = 1'b1;
      alu_out_i = 32'h2001; rd_i = 5'd9; reg_we_i = 1'b1;
      dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFFFFFF;
      #1;
      checks++;
      if (stall_o !== 1'b1) begin
         errors++;
         $display("FAIL ubyte_issue_stall: got stall=%0b, want 1", stall_o);
      end
      step();
      dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h0000F300;
      #1;
      checks++;
      if ({dmem_req, stall_o} !== 2'b00) begin
         errors++;
         $display("FAIL ubyte_wait: got req=%0b stall=%0b, want 0 0", dmem_req, stall_o);
      end
      step();
      idle_inputs();
      checks++;
      if ({valid_o, wb_data_o} !== {1'b1, 32'h000000F3}) begin
         errors++;
         $display("FAIL ubyte_data: got valid=%0b wb=%h, want 1 000000f3", valid_o, wb_data_o);
      end
   endtask

   task automatic test_misaligned();
      valid_i = 1'b1; mem_op_i = 2'b01; mem_size_i = 2'b10; alu_out_i = 32'h3002;
      rd_i = 5'd4; reg_we_i = 1'b1; dmem_gnt = 1'b1;
      #1;
`ifdef MEM_MISALIGN_TRAP_EN
      checks++;
      if ({dmem_req, stall_o} !== 2'b00) begin
         errors++;
         $display("FAIL misalign_trap_bus: got req=%0b stall=%0b, want 0 0", dmem_req, stall_o);
      end
      step();
      idle_inputs();
      checks++;
      if ({valid_o, misaligned_o, reg_we_o, wb_data_o} !== {1'b1, 1'b1, 1'b0, 32'h3002}) begin
         errors++;
         $display("FAIL misalign_trap_wb: got valid=%0b mis=%0b we=%0b wb=%h, want 1 1 0 00003002",
                  valid_o, misaligned_o, reg_we_o, wb_data_o);
      end
`else
      checks++;
      if ({dmem_req, dmem_addr, dmem_be, stall_o} !== {1'b1, 32'h3000, 4'b1111, 1'b1}) begin
         errors++;
         $display("FAIL misalign_align_bus: got req=%0b addr=%h be=%b stall=%0b, want 1 00003000 1111 1",
                  dmem_req, dmem_addr, dmem_be, stall_o);
      end
      step();
      dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h11223344;
      step();
      idle_inputs();
      checks++;
      if ({valid_o, misaligned_o, reg_we_o, wb_data_o} !== {1'b1, 1'b0, 1'b1, 32'h11223344}) begin
         errors++;
         $display("FAIL misalign_align_wb: got valid=%0b mis=%0b we=%0b wb=%h, want 1 0 1 11223344",
                  valid_o, misaligned_o, reg_we_o, wb_data_o);
      end
`endif
   endtask

   task automatic test_reset_in_wait();
      valid_i = 1'b1; mem_op_i = 2'b01; mem_size_i = 2'b10; alu_out_i = 32'h4000;
      rd_i = 5'd6; reg_we_i = 1'b1; pc_i = 32'h80; dmem_gnt = 1'b1;
      step();
      dmem_gnt = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      idle_inputs();
      dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
      #1;
      checks++;
      if ({stall_o, dmem_req} !== 2'b00) begin
         errors++;
         $display("FAIL rst_wait_comb: got stall=%0b req=%0b, want 0 0", stall_o, dmem_req);
      end
      step();
      dmem_rvalid = 1'b0;
      checks++;
      if ({valid_o, reg_we_o, rd_o, pc_o, wb_data_o} !== 71'h0) begin
         errors++;
         $display("FAIL rst_wait_regs: got valid=%0b we=%0b rd=%0d pc=%h wb=%h, want all 0",
                  valid_o, reg_we_o, rd_o, pc_o, wb_data_o);
      end
   endtask

   initial begin
      test_reset();
      test_pass_through();
      test_byte_store();
      test_half_store();
      test_signed_half_load();
      test_unsigned_byte_load();
      test_misaligned();
      test_reset_in_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
